// File: rtl/ifetch_icache.sv
// Instruction fetch stage with a direct-mapped, one-word-per-line I-cache.
// Hits stream one instruction per cycle; misses fetch a word from memory.
module ifetch_icache #(
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iMC_done,
  input  logic [31:0]       iMC_inst,
  output logic              oMC_en,
  output logic [ADDR_W-1:0] oMC_addr,
  input  logic              iIQ_full,
  output logic              oIQ_en,
  output logic [31:0]       oIQ_inst,
  output logic [ADDR_W-1:0] oIQ_pc,
  input  logic              iJP_en,
  input  logic [ADDR_W-1:0] iJP_pc
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic {IDLE, MISS} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                discard_q, discard_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic                mc_en_q, mc_en_d;
  logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
  logic                iq_en_q, iq_en_d;
  logic [31:0]         iq_inst_q, iq_inst_d;
  logic [ADDR_W-1:0]   iq_pc_q, iq_pc_d;

  logic [TAG_W-1:0]    tag_mem [LINES];
  logic [31:0]         data_mem [LINES];

  logic [INDEX_W-1:0]  lk_idx, f_idx;
  logic [TAG_W-1:0]    lk_tag, f_tag;
  logic                hit, fill;

  always_comb begin
    lk_idx    = pc_q[INDEX_W+1:2];
    lk_tag    = pc_q[ADDR_W-1:INDEX_W+2];
    f_idx     = mc_addr_q[INDEX_W+1:2];
    f_tag     = mc_addr_q[ADDR_W-1:INDEX_W+2];
    hit       = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    valid_d   = valid_q;
    mc_en_d   = mc_en_q;
    mc_addr_d = mc_addr_q;
    iq_en_d   = 1'b0;
    iq_inst_d = iq_inst_q;
    iq_pc_d   = iq_pc_q;
    fill      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iJP_en) begin
          pc_d = iJP_pc;
        end else if (!iIQ_full) begin
          if (hit) begin
            iq_en_d   = 1'b1;
            iq_inst_d = data_mem[lk_idx];
            iq_pc_d   = pc_q;
            pc_d      = pc_q + ADDR_W'(4);
          end else begin
            state_d   = MISS;
            mc_en_d   = 1'b1;
            mc_addr_d = pc_q;
          end
        end
      end
      MISS: begin
        if (iJP_en) begin
          pc_d      = iJP_pc;
          discard_d = 1'b1;
        end
        // The request cannot be aborted, so the line is always filled.
        if (iMC_done) begin
          fill           = 1'b1;
          valid_d[f_idx] = 1'b1;
          mc_en_d        = 1'b0;
          state_d        = IDLE;
          discard_d      = 1'b0;
          if (!discard_q && !iJP_en && !iIQ_full) begin
            iq_en_d   = 1'b1;
            iq_inst_d = iMC_inst;
            iq_pc_d   = mc_addr_q;
            pc_d      = mc_addr_q + ADDR_W'(4);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      discard_q <= 1'b0;
      valid_q   <= '0;
      mc_en_q   <= 1'b0;
      mc_addr_q <= '0;
      iq_en_q   <= 1'b0;
      iq_inst_q <= '0;
      iq_pc_q   <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
      mc_en_q   <= mc_en_d;
      mc_addr_q <= mc_addr_d;
      iq_en_q   <= iq_en_d;
      iq_inst_q <= iq_inst_d;
      iq_pc_q   <= iq_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      tag_mem[f_idx]  <= f_tag;
      data_mem[f_idx] <= iMC_inst;
    end
  end

  assign oMC_en   = mc_en_q;
  assign oMC_addr = mc_addr_q;
  assign oIQ_en   = iq_en_q;
  assign oIQ_inst = iq_inst_q;
  assign oIQ_pc   = iq_pc_q;

endmodule
